// File: rtl/gpio_cfg_pkg.sv
// Shared definitions for the GPIO pad-configuration loader: the FSM state
// encoding, default geometry and a small helper used to size the chains.
package gpio_cfg_pkg;

    localparam int DEF_NPADS     = 38;
    localparam int DEF_AREA1PADS = 19;
    localparam int DEF_CFG_W     = 13;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CAPTURE,
        SHIFT_LO,
        SHIFT_HI,
        LOAD,
        DONE
    } cfg_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/gpio_cfg_shifter.sv
// Per-chain word serializer: captures one configuration word (or a zero
// padding word) and presents it MSB first, shifting after each serial clock high.
module gpio_cfg_shifter
    import gpio_cfg_pkg::*;
#(
    parameter int CFG_W = DEF_CFG_W
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             capture,
    input  logic             word_valid,
    input  logic [CFG_W-1:0] word,
    input  logic             shift,
    input  logic             drive,
    output logic             serial_out
);

    logic [CFG_W-1:0] shreg_q;

    // Load the fetched word (zero for padding slots), shift left after each high phase.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            shreg_q <= '0;
        end else if (capture) begin
            shreg_q <= word_valid ? word : '0;
        end else if (shift) begin
            shreg_q <= shreg_q << 1;
        end
    end

    // The chain sees a quiet 0 whenever no bit is being presented.
    assign serial_out = drive & shreg_q[CFG_W-1];

endmodule

// File: rtl/gpio_cfg_loader.sv
// GPIO pad-configuration loader: walks the config store, serializes each pad
// word MSB first onto the pad control chain, then strobes serial_load.
// Build option: define DUAL_CHAIN_EN to drive two chains in parallel
// (chain 1: pads AREA1PADS-1..0, chain 2: pads AREA1PADS..NPADS-1).
module gpio_cfg_loader
    import gpio_cfg_pkg::*;
#(
    parameter int NPADS     = DEF_NPADS,
    parameter int AREA1PADS = DEF_AREA1PADS,
    parameter int CFG_W     = DEF_CFG_W
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(NPADS)-1:0] cfg_addr,
    input  logic [CFG_W-1:0]         cfg_data,
    output logic                     serial_clock,
    output logic                     serial_data_out,
    output logic                     serial_load
`ifdef DUAL_CHAIN_EN
    ,
    output logic [$clog2(NPADS)-1:0] cfg_addr2,
    input  logic [CFG_W-1:0]         cfg_data2,
    output logic                     serial_data_out2
`endif
);

    localparam int AW = $clog2(NPADS);
    localparam int BW = (CFG_W > 1) ? $clog2(CFG_W) : 1;
`ifdef DUAL_CHAIN_EN
    localparam bit DUAL = 1'b1;
`else
    localparam bit DUAL = 1'b0;
`endif
    localparam int CHAIN1_PADS = DUAL ? AREA1PADS : NPADS;
    localparam int CHAIN2_PADS = NPADS - AREA1PADS;
    // Both chains are padded to the same length so they share clock and load.
    localparam int CHAIN_LEN   = DUAL ? max_int(AREA1PADS, CHAIN2_PADS) : NPADS;

    cfg_state_t    state_q, state_d;
    logic [AW-1:0] slot_q;   // words still to send on each chain, minus one
    logic [BW-1:0] bit_q;    // bits still to send in the current word, minus one
    logic          load_q;   // first LOAD cycle already spent
    logic          chain1_valid;
    logic          in_shift;

    // Chain 1 sends slot s as pad s; slots beyond its pad count are zero padding.
    assign chain1_valid = int'(slot_q) < CHAIN1_PADS;
    assign in_shift     = (state_q == SHIFT_LO) || (state_q == SHIFT_HI);

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Slot, bit and load-phase counters; slot stops at 0 and never wraps.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            slot_q <= '0;
            bit_q  <= '0;
            load_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        slot_q <= AW'(CHAIN_LEN - 1);
                        load_q <= 1'b0;
                    end
                end
                CAPTURE:  bit_q <= BW'(CFG_W - 1);
                SHIFT_HI: begin
                    if (bit_q != '0) begin
                        bit_q <= bit_q - 1'b1;
                    end else if (slot_q != '0) begin
                        slot_q <= slot_q - 1'b1;
                    end
                end
                LOAD:     load_q <= 1'b1;
                default:  ;
            endcase
        end
    end

    // Next-state and decoded outputs; outputs depend only on state so reset clears them at once.
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d      = state_q;
        busy         = (state_q != IDLE) && (state_q != DONE);
        done         = (state_q == DONE);
        serial_clock = (state_q == SHIFT_HI);
        serial_load  = (state_q == LOAD);
        cfg_addr     = '0;
        case (state_q)
            IDLE:     if (start) state_d = FETCH;
            FETCH: begin
                state_d = CAPTURE;
                if (chain1_valid) cfg_addr = slot_q;
            end
            CAPTURE:  state_d = SHIFT_LO;
            SHIFT_LO: state_d = SHIFT_HI;
            SHIFT_HI: begin
                if (bit_q != '0)       state_d = SHIFT_LO;
                else if (slot_q != '0) state_d = FETCH;
                else                   state_d = LOAD;
            end
            LOAD:     if (load_q) state_d = DONE;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    gpio_cfg_shifter #(.CFG_W(CFG_W)) u_shift1 (
        .clk        (clk),
        .resetn     (resetn),
        .capture    (state_q == CAPTURE),
        .word_valid (chain1_valid),
        .word       (cfg_data),
        .shift      (state_q == SHIFT_HI),
        .drive      (in_shift),
        .serial_out (serial_data_out)
    );

`ifdef DUAL_CHAIN_EN
    logic chain2_valid;

    // Chain 2 runs lowest pad first: slot s carries pad NPADS-1-s, padding first.
    assign chain2_valid = int'(slot_q) < CHAIN2_PADS;
    assign cfg_addr2    = ((state_q == FETCH) && chain2_valid) ? (AW'(NPADS - 1) - slot_q) : '0;

    gpio_cfg_shifter #(.CFG_W(CFG_W)) u_shift2 (
        .clk        (clk),
        .resetn     (resetn),
        .capture    (state_q == CAPTURE),
        .word_valid (chain2_valid),
        .word       (cfg_data2),
        .shift      (state_q == SHIFT_HI),
        .drive      (in_shift),
        .serial_out (serial_data_out2)
    );
`endif

endmodule
